fetch_queue_multi: RTL and testbench

- Instruction fetch queue between the I-cache line fill path and the decoder.
- Accepts one cache line of WORDS_PER_LINE instruction words per push, starting at a programmable word offset so branch targets can land mid-line.
- Presents up to POP_MAX oldest words per cycle, and the decoder consumes a variable count of 0..POP_MAX words each cycle.
- Successor of the single-word fetch FIFO. Adds exact occupancy tracking, multi-word pop, offset-aware push, redirect (flush with simultaneous refill) and a drop indication.

---
 rtl/fetch_queue_multi.sv | 96 +++++++++
 tb/tb_fetch_queue_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_multi.sv
// Instruction fetch queue: accepts one cache line per push at a word offset and
// presents up to POP_MAX oldest words per cycle, with redirect (flush) and drop reporting.
module fetch_queue_multi #(
   parameter int DEPTH          = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int POP_MAX        = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic                                   push,
   input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0]   line_in,
   input  logic [$clog2(WORDS_PER_LINE)-1:0]      line_offset,
   output logic                                   full,
   output logic                                   push_drop,
   input  logic [$clog2(POP_MAX+1)-1:0]           pop_cnt,
   output logic [POP_MAX*DATA_WIDTH-1:0]          data_out,
   output logic [POP_MAX-1:0]                     data_valid,
   output logic                                   empty,
   output logic [$clog2(DEPTH):0]                 count,
   output logic [$clog2(DEPTH):0]                 wp,
   output logic [$clog2(DEPTH):0]                 rp
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int OW = $clog2(WORDS_PER_LINE);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] free_words;
   logic [PW-1:0] pop_req;
   logic [PW-1:0] eff_pop;
   logic [PW-1:0] push_len;
   logic          accept;
   logic          do_write;
   logic [AW-1:0] wbase;

   // The extra wrap bit on each pointer separates a full queue from an empty one.
   assign count      = wp - rp;
   assign free_words = PW'(DEPTH) - count;
   assign full       = free_words < PW'(WORDS_PER_LINE);
   assign empty      = (count == '0);

   assign pop_req  = PW'(pop_cnt);
   assign eff_pop  = (pop_req < count) ? pop_req : count;
   assign push_len = PW'(WORDS_PER_LINE) - PW'(line_offset);
   assign accept   = push && !full;

   // A flush empties the queue, so its accompanying line always fits at address 0.
   assign do_write = flush ? push : accept;
   assign wbase    = flush ? '0 : wp[AW-1:0];

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         push_drop <= 1'b0;
      end else if (flush) begin
         rp        <= '0;
         wp        <= push ? push_len : '0;
         push_drop <= 1'b0;
      end else begin
         rp        <= rp + eff_pop;
         wp        <= accept ? wp + push_len : wp;
         push_drop <= push && full;
      end
   end

   // NOTE: the storage array carries no reset; the pointers alone define which
   // words are valid, and reset-free arrays map onto plain register files.
   always_ff @(posedge clk) begin
      if (do_write && !reset) begin
         for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (OW'(k) >= line_offset)
               mem[wbase + AW'(k) - AW'(line_offset)] <= line_in[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // NOTE: outputs get defaults before the loop so no path leaves them unassigned
   // and no latch is inferred.
   always_comb begin
      data_out   = '0;
      data_valid = '0;
      for (int i = 0; i < POP_MAX; i++) begin
         data_valid[i] = PW'(i) < count;
         if (data_valid[i])
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rp[AW-1:0] + AW'(i)];
      end
   end

endmodule

// File: tb/tb_fetch_queue_multi.sv
// Directed self-checking bench for fetch_queue_multi at DEPTH=16, WORDS_PER_LINE=4,
// POP_MAX=2, DATA_WIDTH=32, with hand-computed expected values.
module tb_fetch_queue_multi;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          push;
   logic [127:0]  line_in;
   logic [1:0]    line_offset;
   logic          full;
   logic          push_drop;
   logic [1:0]    pop_cnt;
   logic [63:0]   data_out;
   logic [1:0]    data_valid;
   logic          empty;
   logic [4:0]    count;
   logic [4:0]    wp;
   logic [4:0]    rp;

   int tests  = 0;
   int errors = 0;

   fetch_queue_multi dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push        (push),
      .line_in     (line_in),
      .line_offset (line_offset),
      .full        (full),
      .push_drop   (push_drop),
      .pop_cnt     (pop_cnt),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .empty       (empty),
      .count       (count),
      .wp          (wp),
      .rp          (rp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Line j of a group: word k = base | (j << 4) | k.
   function automatic logic [127:0] mk_line(input logic [31:0] base, input int j);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = base | 32'(j << 4) | 32'(k);
      return l;
   endfunction

   initial begin
      reset = 1'b1; flush = 1'b0; push = 1'b0; line_in = '0; line_offset = '0; pop_cnt = '0;
      tick(); tick();
      reset = 1'b0;

      check("rst_count", 64'(count), 64'd0);
      check("rst_wp", 64'(wp), 64'd0);
      check("rst_rp", 64'(rp), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_valid", 64'(data_valid), 64'd0);
      check("rst_data", data_out, 64'd0);
      check("rst_drop", 64'(push_drop), 64'd0);

      // 1. single push and pop
      push = 1'b1; line_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; line_offset = 2'd0;
      tick();
      push = 1'b0;
      check("t1_count", 64'(count), 64'd4);
      check("t1_data", data_out, {32'hA1, 32'hA0});
      check("t1_valid", 64'(data_valid), 64'b11);
      check("t1_empty", 64'(empty), 64'd0);
      pop_cnt = 2'd2;
      tick();
      pop_cnt = 2'd0;
      check("t1_pop_count", 64'(count), 64'd2);
      check("t1_pop_data", data_out, {32'hA3, 32'hA2});

      // 2. offset push into an empty queue, then over-pop clamp
      reset = 1'b1; tick(); reset = 1'b0;
      push = 1'b1; line_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0}; line_offset = 2'd3;
      tick();
      push = 1'b0;
      check("t2_count", 64'(count), 64'd1);
      check("t2_data", data_out, {32'h0, 32'hB3});
      check("t2_valid", 64'(data_valid), 64'b01);
      pop_cnt = 2'd2;
      tick();
      pop_cnt = 2'd0;
      check("t2_clamp_count", 64'(count), 64'd0);
      check("t2_clamp_empty", 64'(empty), 64'd1);
      check("t2_clamp_rp", 64'(rp), 64'd1);
      check("t2_clamp_wp", 64'(wp), 64'd1);

      // 3. fill to capacity and drop; lines land at indices 1..16 (wrapping)
      line_offset = 2'd0;
      for (int j = 0; j < 4; j++) begin
         push = 1'b1; line_in = mk_line(32'hC000_0000, j);
         tick();
      end
      check("t3_full_count", 64'(count), 64'd16);
      check("t3_full", 64'(full), 64'd1);
      check("t3_full_wp", 64'(wp), 64'd17);
      line_in = {4{32'hEEEE_EEEE}};
      tick();
      push = 1'b0;
      check("t3_drop", 64'(push_drop), 64'd1);
      check("t3_drop_count", 64'(count), 64'd16);
      check("t3_drop_wp", 64'(wp), 64'd17);
      check("t3_drop_data", data_out, {32'hC000_0001, 32'hC000_0000});
      pop_cnt = 2'd2;
      tick();
      check("t3_drop_pulse", 64'(push_drop), 64'd0);
      check("t3_pop1_count", 64'(count), 64'd14);
      check("t3_pop1_full", 64'(full), 64'd1);
      tick();
      pop_cnt = 2'd0;
      check("t3_pop2_count", 64'(count), 64'd12);
      check("t3_pop2_full", 64'(full), 64'd0);
      check("t3_pop2_data", data_out, {32'hC000_0011, 32'hC000_0010});

      // 4. wrap: 5 pushes with concurrent pops, then drain to rp=18, wp=20
      reset = 1'b1; tick(); reset = 1'b0;
      line_offset = 2'd0;
      for (int j = 1; j <= 5; j++) begin
         push = 1'b1; pop_cnt = 2'd2; line_in = mk_line(32'h4000_0000, j);
         tick();
      end
      push = 1'b0;
      check("t4_mid_wp", 64'(wp), 64'd20);
      check("t4_mid_rp", 64'(rp), 64'd8);
      for (int j = 0; j < 5; j++) tick();
      pop_cnt = 2'd0;
      check("t4_wp", 64'(wp), 64'd20);
      check("t4_rp", 64'(rp), 64'd18);
      check("t4_count", 64'(count), 64'd2);
      check("t4_data", data_out, {32'h4000_0053, 32'h4000_0052});
      push = 1'b1; line_in = {32'hF3, 32'hF2, 32'hF1, 32'hF0}; line_offset = 2'd1;
      tick();
      push = 1'b0;
      check("t4_off_count", 64'(count), 64'd5);
      check("t4_off_wp", 64'(wp), 64'd23);
      pop_cnt = 2'd2;
      tick();
      pop_cnt = 2'd0;
      check("t4_off_data", data_out, {32'hF2, 32'hF1});
      check("t4_off_count2", 64'(count), 64'd3);

      // 5. redirect with simultaneous refill and ignored pop
      push = 1'b1; line_in = mk_line(32'h5000_0000, 0); line_offset = 2'd0;
      tick();
      push = 1'b0;
      check("t5_pre_count", 64'(count), 64'd7);
      push = 1'b1; line_in = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; line_offset = 2'd2;
      tick();
      check("t5_pre9_count", 64'(count), 64'd9);
      flush = 1'b1; pop_cnt = 2'd2;
      tick();
      flush = 1'b0; push = 1'b0; pop_cnt = 2'd0;
      check("t5_rp", 64'(rp), 64'd0);
      check("t5_wp", 64'(wp), 64'd2);
      check("t5_count", 64'(count), 64'd2);
      check("t5_data", data_out, {32'hD3, 32'hD2});
      check("t5_drop", 64'(push_drop), 64'd0);

      // 6. reset mid-operation with push asserted
      push = 1'b1; line_in = mk_line(32'h6000_0000, 1); line_offset = 2'd3;
      tick();
      line_offset = 2'd0;
      tick();
      check("t6_pre_count", 64'(count), 64'd7);
      reset = 1'b1;
      tick();
      reset = 1'b0; push = 1'b0;
      check("t6_count", 64'(count), 64'd0);
      check("t6_wp", 64'(wp), 64'd0);
      check("t6_rp", 64'(rp), 64'd0);
      check("t6_empty", 64'(empty), 64'd1);
      check("t6_drop", 64'(push_drop), 64'd0);
      check("t6_valid", 64'(data_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
